pc_fetch_unit: RTL

//  Parametrised PC generator for the RISCV core fetch stage; next generation of the basic PC register.

---
 rtl/pc_fetch_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC generator with handshake,
// trap entry/return, optional 16-bit stepping and debug halt.
module pc_fetch_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
    parameter int                COMPRESSED   = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    input  logic            instr_is_16,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            trap,
    input  logic            mret,
    output logic [XLEN-1:0] epc,
    output logic            misalign_err,
    input  logic            halt,
    input  logic            resume,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic C_EN = (COMPRESSED != 0);

    state_t          st_q, st_d;
    logic [XLEN-1:0] pc_d, epc_d;
    logic            err_d;
    logic            misalign;
    logic [XLEN-1:0] step;

    assign state       = st_q;
    assign fetch_valid = (st_q == RUN) & ~stall;

    // Target alignment: 2-byte granularity only with C-ext
    assign misalign = C_EN ? jump_addr[0] : (|jump_addr[1:0]);

    // Fetch step size: +2 for a 16-bit instruction in C-ext builds
    assign step = (C_EN && instr_is_16) ? XLEN'(2) : XLEN'(4);

    // State, PC, EPC and error-pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q         <= BOOT;
            pc           <= RESET_VECTOR;
            epc          <= '0;
            misalign_err <= 1'b0;
        end else begin
            st_q         <= st_d;
            pc           <= pc_d;
            epc          <= epc_d;
            misalign_err <= err_d;
        end
    end

    // Next-state and prioritised PC update
    always_comb begin
        st_d  = st_q;
        pc_d  = pc;
        epc_d = epc;
        err_d = 1'b0;
        unique case (st_q)
            BOOT: st_d = RUN;
            RUN: begin
                if (trap) begin
                    epc_d = pc;
                    pc_d  = TRAP_VECTOR;
                end else if (mret) begin
                    pc_d = epc;
                end else if (jump) begin
                    if (misalign) begin
                        epc_d = pc;
                        pc_d  = TRAP_VECTOR;
                        err_d = 1'b1;
                    end else begin
                        pc_d = jump_addr;
                    end
                end else if (fetch_valid && fetch_ready) begin
                    pc_d = pc + step;
                end
                if (halt) st_d = HALT;
            end
            HALT: begin
                if (resume) st_d = RUN;
            end
            default: st_d = BOOT;
        endcase
    end

endmodule
